fifo_burst_reader: RTL and testbench

Drains the 32-bit synchronous FIFO directly upstream and presents its words as fixed-length bursts on a valid/ready output stream. A burst starts when the FIFO reports half-full. It also starts on an idle timeout when data has been waiting too long. Bursts cut short by an empty FIFO in timeout mode are zero-padded to full length. A 2-entry output buffer decouples downstream back-pressure from FIFO reads, so no combinational path runs from `m_ready` to `fifo_rd_en`.

---
 rtl/fifo_burst_reader.sv | 175 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an upstream synchronous FIFO into fixed-length
// bursts on a valid/ready stream. Bursts start on FIFO half-full or after an
// idle timeout; timeout bursts that run out of data are zero-padded to full
// length. A 2-entry output buffer keeps m_ready off the FIFO read path.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_half_full,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_pad,
    output logic [15:0]           burst_cnt
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    state_t                state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  flush_q;
    logic [IDLE_W-1:0]     idle_cnt_q;
    logic [15:0]           burst_cnt_q;

    // Output buffer: entry 0 is always the head, so m_* come straight from flops.
    logic [DATA_WIDTH-1:0] buf0_data_q, buf1_data_q;
    logic                  buf0_last_q, buf1_last_q;
    logic                  buf0_pad_q,  buf1_pad_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;

    logic                  pad_push;
    logic                  push;
    logic                  pop;
    logic                  push_last;
    logic                  push_pad;
    logic [DATA_WIDTH-1:0] push_data;

    // Push/pop decisions; the read strobe looks only at registered state and fifo_empty.
    always_comb begin
        fifo_rd_en = (state_q == S_DRAIN) && !fifo_empty && (occ_q < 2'd2);
        pad_push   = (state_q == S_PAD) && (occ_q < 2'd2);
        push       = fifo_rd_en || pad_push;
        pop        = (occ_q != 2'd0) && m_ready;
        push_last  = (beat_q == LAST_BEAT);
        push_pad   = pad_push;
        push_data  = pad_push ? '0 : fifo_data;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    end

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf0_data_q;
    assign m_last    = buf0_last_q;
    assign m_pad     = buf0_pad_q;
    assign burst_cnt = burst_cnt_q;

    // Two-entry shift buffer: pops shift entry 1 forward, pushes fill the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_data_q <= '0;
            buf0_last_q <= 1'b0;
            buf0_pad_q  <= 1'b0;
            buf1_data_q <= '0;
            buf1_last_q <= 1'b0;
            buf1_pad_q  <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            if (pop) begin
                if (push && occ_q == 2'd1) begin
                    buf0_data_q <= push_data;
                    buf0_last_q <= push_last;
                    buf0_pad_q  <= push_pad;
                end else if (occ_q == 2'd2) begin
                    buf0_data_q <= buf1_data_q;
                    buf0_last_q <= buf1_last_q;
                    buf0_pad_q  <= buf1_pad_q;
                end
            end else if (push) begin
                if (occ_q == 2'd0) begin
                    buf0_data_q <= push_data;
                    buf0_last_q <= push_last;
                    buf0_pad_q  <= push_pad;
                end else begin
                    buf1_data_q <= push_data;
                    buf1_last_q <= push_last;
                    buf1_pad_q  <= push_pad;
                end
            end
            occ_q <= occ_d;
        end
    end

    // Burst sequencing: IDLE waits for half-full or timeout, DRAIN reads, PAD fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            flush_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_half_full) begin
                        state_q    <= S_DRAIN;
                        flush_q    <= 1'b0;
                        idle_cnt_q <= '0;
                    end else if (!fifo_empty) begin
                        if (idle_cnt_q == IDLE_MAX) begin
                            state_q    <= S_DRAIN;
                            flush_q    <= 1'b1;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (fifo_rd_en) begin
                        if (push_last) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end else if (fifo_empty && flush_q && occ_q < 2'd2) begin
                        // Timeout burst ran dry: finish it with padding.
                        state_q <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (pad_push) begin
                        if (push_last) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    // Completed-burst counter, bumped when the last word of a burst is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= 16'd0;
        end else if (pop && buf0_last_q) begin
            burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader with a behavioural upstream FIFO
// and an output capture log.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_half_full = 1'b0;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_pad;
    logic [15:0] burst_cnt;

    fifo_burst_reader #(.DATA_WIDTH(32), .BURST_LEN(8), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_half_full (fifo_half_full),
        .fifo_data      (fifo_data),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_pad          (m_pad),
        .burst_cnt      (burst_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: write side owned by the stimulus, read side by the clock.
    logic [31:0] fmem [0:255];
    int          wr_ptr  = 0;
    int          rd_ptr  = 0;
    int          clr_ptr = 0;
    int          rd_cnt  = 0;
    bit          hf_force = 1'b0;

    // Output capture log.
    logic [31:0] od [0:511];
    logic        ol [0:511];
    logic        op [0:511];
    int          oc = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int base     = 0;
    int rdb      = 0;

    // Reads and accepted words happen on the rising edge.
    always @(posedge clk) begin
        if (rd_ptr < clr_ptr) begin
            rd_ptr = clr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            rd_ptr = rd_ptr + 1;
            rd_cnt = rd_cnt + 1;
        end
        if (m_valid && m_ready) begin
            od[oc] = m_data;
            ol[oc] = m_last;
            op[oc] = m_pad;
            oc = oc + 1;
        end
    end

    // FIFO flags refresh on the falling edge, away from the DUT sampling edge.
    always @(negedge clk) begin
        fifo_empty     = (wr_ptr == rd_ptr);
        fifo_half_full = ((wr_ptr - rd_ptr) >= 8) || hf_force;
        fifo_data      = (wr_ptr != rd_ptr) ? fmem[rd_ptr % 256] : 32'd0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        fmem[wr_ptr % 256] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_ptr = wr_ptr;
        hf_force = 1'b0;
        step();
        step();
        rst = 1'b0;
        base = oc;
        rdb = rd_cnt;
    endtask

    task automatic wait_out(input int n, input string tag, output int steps);
        steps = 0;
        while ((oc - base) < n && steps < 300) begin
            step();
            steps++;
        end
        chk(tag, 32'(oc - base), 32'(n));
    endtask

    initial begin
        int       st;
        logic [31:0] exp_d;

        // Reset values.
        do_reset();
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_pad", {31'd0, m_pad}, 32'd0);
        chk("rst_bcnt", {16'd0, burst_cnt}, 32'd0);

        // Half-full burst: 9 words, 8 come out back to back.
        m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push(32'(i));
        step();
        chk("t1_first_rd", {31'd0, fifo_rd_en}, 32'd1);
        chk("t1_no_valid_yet", {31'd0, m_valid}, 32'd0);
        step();
        chk("t1_lat_valid", {31'd0, m_valid}, 32'd1);
        chk("t1_lat_data", m_data, 32'd1);
        wait_out(8, "t1_count", st);
        chk("t1_cycles", 32'(st), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_data%0d", i), od[base + i], 32'(i + 1));
            chk($sformatf("t1_last%0d", i), {31'd0, ol[base + i]}, (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("t1_pad%0d", i), {31'd0, op[base + i]}, 32'd0);
        end
        step();
        chk("t1_bcnt", {16'd0, burst_cnt}, 32'd1);
        chk("t1_left", 32'(wr_ptr - rd_ptr), 32'd1);

        // Timeout flush: 3 words, 16 idle cycles, then 5 pads.
        do_reset();
        m_ready = 1'b1;
        push(32'h0A); push(32'h0B); push(32'h0C);
        repeat (15) step();
        chk("t2_no_rd_15", {31'd0, fifo_rd_en}, 32'd0);
        step();
        chk("t2_rd_16", {31'd0, fifo_rd_en}, 32'd1);
        chk("t2_no_reads", 32'(rd_cnt - rdb), 32'd0);
        wait_out(8, "t2_count", st);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i == 0) ? 32'h0A : (i == 1) ? 32'h0B : (i == 2) ? 32'h0C : 32'd0;
            chk($sformatf("t2_data%0d", i), od[base + i], exp_d);
            chk($sformatf("t2_pad%0d", i), {31'd0, op[base + i]}, (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("t2_last%0d", i), {31'd0, ol[base + i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("t2_bcnt", {16'd0, burst_cnt}, 32'd1);

        // Back-pressure: stop accepting after 2 words for 10 cycles.
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push(32'h100 + 32'(i));
        wait_out(2, "t3_pre", st);
        m_ready = 1'b0;
        st = rd_cnt;
        step();
        chk("t3_hold_first", m_data, 32'h103);
        repeat (9) step();
        chk("t3_pause_reads", 32'(rd_cnt - st), 32'd1);
        chk("t3_rd_low", {31'd0, fifo_rd_en}, 32'd0);
        chk("t3_valid_held", {31'd0, m_valid}, 32'd1);
        chk("t3_hold_last", m_data, 32'h103);
        m_ready = 1'b1;
        wait_out(8, "t3_count", st);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_data%0d", i), od[base + i], 32'h101 + 32'(i));
            chk($sformatf("t3_last%0d", i), {31'd0, ol[base + i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("t3_bcnt", {16'd0, burst_cnt}, 32'd1);
        chk("t3_reads", 32'(rd_cnt - rdb), 32'd8);

        // Non-flush stall: FIFO runs dry after 5 words, no padding.
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push(32'h200 + 32'(i));
        hf_force = 1'b1;
        step();
        hf_force = 1'b0;
        repeat (25) step();
        chk("t4_stalled_count", 32'(oc - base), 32'd5);
        chk("t4_stall_valid", {31'd0, m_valid}, 32'd0);
        chk("t4_stall_rd", {31'd0, fifo_rd_en}, 32'd0);
        for (int i = 1; i <= 3; i++) push(32'h205 + 32'(i));
        step();
        chk("t4_resume_rd", {31'd0, fifo_rd_en}, 32'd1);
        wait_out(8, "t4_count", st);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_data%0d", i), od[base + i], 32'h201 + 32'(i));
            chk($sformatf("t4_pad%0d", i), {31'd0, op[base + i]}, 32'd0);
            chk($sformatf("t4_last%0d", i), {31'd0, ol[base + i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("t4_bcnt", {16'd0, burst_cnt}, 32'd1);

        // Mid-burst reset after 4 accepted words.
        base = oc;
        for (int i = 1; i <= 9; i++) push(32'h300 + 32'(i));
        wait_out(4, "t5_pre", st);
        rst = 1'b1;
        #1;
        chk("t5_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_data", m_data, 32'd0);
        chk("t5_last", {31'd0, m_last}, 32'd0);
        chk("t5_pad", {31'd0, m_pad}, 32'd0);
        chk("t5_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("t5_bcnt", {16'd0, burst_cnt}, 32'd0);
        step();
        step();
        chk("t5_left", 32'(wr_ptr - rd_ptr), 32'd4);
        rst = 1'b0;
        base = oc;
        for (int i = 0; i < 6; i++) push(32'h320 + 32'(i));
        wait_out(8, "t5_count", st);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 4) ? 32'h306 + 32'(i) : 32'h320 + 32'(i - 4);
            chk($sformatf("t5_data%0d", i), od[base + i], exp_d);
            chk($sformatf("t5_last%0d", i), {31'd0, ol[base + i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("t5_bcnt_after", {16'd0, burst_cnt}, 32'd1);

        // Counter wrap: preset the count to its maximum, then complete one burst.
        do_reset();
        force dut.burst_cnt_q = 16'hFFFF;
        step();
        release dut.burst_cnt_q;
        step();
        chk("t6_preset", {16'd0, burst_cnt}, 32'h0000FFFF);
        for (int i = 1; i <= 9; i++) push(32'h400 + 32'(i));
        wait_out(8, "t6_count", st);
        chk("t6_last_word", od[base + 7], 32'h408);
        step();
        chk("t6_wrap", {16'd0, burst_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
